// File: rtl/ddr4_mc_regfile_pkg.sv
// Shared register map, bit positions and watchdog state encoding for the DDR4 MC register file.
package ddr4_mc_regfile_pkg;

  localparam int CH_STRIDE   = 'h20;
  localparam int CH_OFF_W    = $clog2(CH_STRIDE);
  localparam int CH_IDX_W    = 3;
  localparam int GLOBAL_BASE = 'h100;

  localparam logic [CH_OFF_W-1:0] REG_STATUS = 5'h00;
  localparam logic [CH_OFF_W-1:0] REG_CALIB  = 5'h08;
  localparam logic [CH_OFF_W-1:0] REG_ECC    = 5'h10;
  localparam logic [CH_OFF_W-1:0] REG_CTRL   = 5'h18;

  localparam int CALIB_DONE_BIT    = 0;
  localparam int CALIB_TIMEOUT_BIT = 1;
  localparam int CTRL_EN_UE_BIT    = 0;
  localparam int CTRL_EN_TO_BIT    = 1;
  localparam int ECC_UE_LSB        = 32;

  typedef enum logic [1:0] {
    WDT_IDLE,
    WDT_COUNT,
    WDT_DONE,
    WDT_TIMEOUT
  } wdt_state_e;

endpackage

// File: rtl/ddr4_mc_ch_stat.sv
// Per-channel status block: input snapshots, saturating ECC counters, CTRL and interrupt pending.
// Calibration watchdog present only when DDR4_MC_REGFILE_CALIB_WDT_EN is defined.
module ddr4_mc_ch_stat
  import ddr4_mc_regfile_pkg::*;
#(
  parameter int STATUS_W          = 16,
  parameter int CNT_W             = 32,
  parameter int CALIB_TIMEOUT_CYC = 1048576
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic                calib_complete_i,
  input  logic                ecc_ce_i,
  input  logic                ecc_ue_i,
  input  logic                calib_w1c_i,
  input  logic                ecc_clr_i,
  input  logic                ctrl_we_i,
  input  logic [1:0]          ctrl_wdata_i,
  output logic [STATUS_W-1:0] status_o,
  output logic                calib_done_o,
  output logic                calib_timeout_o,
  output logic [CNT_W-1:0]    ce_cnt_o,
  output logic [CNT_W-1:0]    ue_cnt_o,
  output logic [1:0]          ctrl_o,
  output logic                pending_o
);

  logic [STATUS_W-1:0] status_q;
  logic                calib_q;
  logic [CNT_W-1:0]    ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0]    ue_cnt_q, ue_cnt_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic                timeout;

  // A clear in the same cycle as a pulse leaves the pulse counted.
  function automatic logic [CNT_W-1:0] ecc_cnt_next(input logic clr, input logic pulse,
                                                    input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (pulse && !(&base)) return base + CNT_W'(1);
    return base;
  endfunction

  always_comb begin
    ce_cnt_d = ecc_cnt_next(ecc_clr_i, ecc_ce_i, ce_cnt_q);
    ue_cnt_d = ecc_cnt_next(ecc_clr_i, ecc_ue_i, ue_cnt_q);
    ctrl_d   = ctrl_we_i ? ctrl_wdata_i : ctrl_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      status_q <= '0;
      calib_q  <= 1'b0;
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
      ctrl_q   <= '0;
    end else begin
      status_q <= status_i;
      calib_q  <= calib_complete_i;
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
      ctrl_q   <= ctrl_d;
    end
  end

`ifdef DDR4_MC_REGFILE_CALIB_WDT_EN
  localparam int WDT_W = $clog2(CALIB_TIMEOUT_CYC);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(CALIB_TIMEOUT_CYC - 1);

  wdt_state_e       wdt_state_q, wdt_state_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             timeout_q, timeout_d;
  logic             recal;

  // calib_q holds last cycle's level, so this is a 1->0 edge.
  assign recal = calib_q & ~calib_complete_i;

  always_comb begin
    wdt_state_d = wdt_state_q;
    wdt_cnt_d   = wdt_cnt_q;
    timeout_d   = timeout_q & ~calib_w1c_i;
    case (wdt_state_q)
      WDT_IDLE, WDT_COUNT: begin
        if (calib_complete_i) begin
          wdt_state_d = WDT_DONE;
        end else if (wdt_cnt_q == WDT_LAST) begin
          wdt_state_d = WDT_TIMEOUT;
          timeout_d   = 1'b1;
        end else begin
          wdt_state_d = WDT_COUNT;
          wdt_cnt_d   = wdt_cnt_q + WDT_W'(1);
        end
      end
      WDT_DONE, WDT_TIMEOUT: begin
        if (recal) begin
          wdt_state_d = WDT_COUNT;
          wdt_cnt_d   = '0;
        end
      end
      default: wdt_state_d = WDT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wdt_state_q <= WDT_IDLE;
      wdt_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      wdt_state_q <= wdt_state_d;
      wdt_cnt_q   <= wdt_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_w1c;
  assign unused_w1c = calib_w1c_i;
  assign timeout    = 1'b0;
`endif

  assign status_o        = status_q;
  assign calib_done_o    = calib_q;
  assign calib_timeout_o = timeout;
  assign ce_cnt_o        = ce_cnt_q;
  assign ue_cnt_o        = ue_cnt_q;
  assign ctrl_o          = ctrl_q;
  assign pending_o       = ((|ue_cnt_q) & ctrl_q[CTRL_EN_UE_BIT]) |
                           (timeout & ctrl_q[CTRL_EN_TO_BIT]);

endmodule

// File: rtl/ddr4_mc_regfile.sv
// DDR4 MC status/control register file: address decode, registered read mux and combined IRQ.
// Optional calibration watchdog enabled by defining DDR4_MC_REGFILE_CALIB_WDT_EN.
module ddr4_mc_regfile
  import ddr4_mc_regfile_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int STATUS_W          = 16,
  parameter int CNT_W             = 32,
  parameter int CALIB_TIMEOUT_CYC = 1048576,
  parameter int ADDR_W            = 32,
  parameter int DATA_W            = 64,
  parameter int BSEL_W            = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         config_en_i,
  input  logic [BSEL_W-1:0]            config_wben_i,
  input  logic [ADDR_W-1:0]            config_addr_i,
  input  logic [DATA_W-1:0]            config_wdata_i,
  output logic [DATA_W-1:0]            config_rdata_o,
  input  logic [NUM_CH*STATUS_W-1:0]   ddr4_status_i,
  input  logic [NUM_CH-1:0]            ddr4_calib_complete_i,
  input  logic [NUM_CH-1:0]            ddr4_ecc_ce_i,
  input  logic [NUM_CH-1:0]            ddr4_ecc_ue_i,
  output logic                         irq_o
);

  logic                wr, rd, ch_hit, glb_hit;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [CH_OFF_W-1:0] ch_off;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                irq_q, irq_d;
  logic [NUM_CH-1:0]   pending;

  logic [STATUS_W-1:0] ch_status     [NUM_CH];
  logic                ch_calib_done [NUM_CH];
  logic                ch_timeout    [NUM_CH];
  logic [CNT_W-1:0]    ch_ce_cnt     [NUM_CH];
  logic [CNT_W-1:0]    ch_ue_cnt     [NUM_CH];
  logic [1:0]          ch_ctrl       [NUM_CH];

  logic unused_wdata;
  assign unused_wdata = ^config_wdata_i[DATA_W-1:2];

  assign wr      = config_en_i & (|config_wben_i);
  assign rd      = config_en_i & ~(|config_wben_i);
  assign ch_idx  = config_addr_i[CH_OFF_W +: CH_IDX_W];
  assign ch_off  = config_addr_i[CH_OFF_W-1:0];
  assign ch_hit  = (config_addr_i < ADDR_W'(GLOBAL_BASE)) && (int'(ch_idx) < NUM_CH);
  assign glb_hit = (config_addr_i == ADDR_W'(GLOBAL_BASE));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr & ch_hit & (ch_idx == CH_IDX_W'(c));

    ddr4_mc_ch_stat #(
      .STATUS_W          (STATUS_W),
      .CNT_W             (CNT_W),
      .CALIB_TIMEOUT_CYC (CALIB_TIMEOUT_CYC)
    ) u_ch_stat (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .status_i         (ddr4_status_i[c*STATUS_W +: STATUS_W]),
      .calib_complete_i (ddr4_calib_complete_i[c]),
      .ecc_ce_i         (ddr4_ecc_ce_i[c]),
      .ecc_ue_i         (ddr4_ecc_ue_i[c]),
      .calib_w1c_i      (sel & (ch_off == REG_CALIB) & config_wben_i[0] &
                         config_wdata_i[CALIB_TIMEOUT_BIT]),
      .ecc_clr_i        (sel & (ch_off == REG_ECC)),
      .ctrl_we_i        (sel & (ch_off == REG_CTRL) & config_wben_i[0]),
      .ctrl_wdata_i     (config_wdata_i[1:0]),
      .status_o         (ch_status[c]),
      .calib_done_o     (ch_calib_done[c]),
      .calib_timeout_o  (ch_timeout[c]),
      .ce_cnt_o         (ch_ce_cnt[c]),
      .ue_cnt_o         (ch_ue_cnt[c]),
      .ctrl_o           (ch_ctrl[c]),
      .pending_o        (pending[c])
    );
  end

  // Non-read cycles load zero so rdata is only non-zero right after a read.
  always_comb begin
    rdata_d = '0;
    if (rd && ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == c[CH_IDX_W-1:0]) begin
          case (ch_off)
            REG_STATUS: rdata_d[STATUS_W-1:0] = ch_status[c];
            REG_CALIB: begin
              rdata_d[CALIB_DONE_BIT]    = ch_calib_done[c];
              rdata_d[CALIB_TIMEOUT_BIT] = ch_timeout[c];
            end
            REG_ECC: begin
              rdata_d[CNT_W-1:0]          = ch_ce_cnt[c];
              rdata_d[ECC_UE_LSB +: CNT_W] = ch_ue_cnt[c];
            end
            REG_CTRL: rdata_d[1:0] = ch_ctrl[c];
            default: ;
          endcase
        end
      end
    end else if (rd && glb_hit) begin
      rdata_d[NUM_CH-1:0] = pending;
    end
  end

  assign irq_d = |pending;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign config_rdata_o = rdata_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_ddr4_mc_regfile.sv
// Scoreboard bench for ddr4_mc_regfile; expectations follow DDR4_MC_REGFILE_CALIB_WDT_EN when defined.
module tb_ddr4_mc_regfile;

  localparam int NUM_CH = 2;
  localparam int STATUS_W = 16;
  localparam int CNT_W = 4;
  localparam int TO_CYC = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BSEL_W = 8;
`ifdef DDR4_MC_REGFILE_CALIB_WDT_EN
  localparam logic [63:0] TO_BIT = 64'h2;
`else
  localparam logic [63:0] TO_BIT = 64'h0;
`endif

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       en = 1'b0;
  logic [BSEL_W-1:0]          wben = '0;
  logic [ADDR_W-1:0]          addr = '0;
  logic [DATA_W-1:0]          wdata = '0;
  logic [NUM_CH*STATUS_W-1:0] status = '0;
  logic [NUM_CH-1:0]          calib = '0;
  logic [NUM_CH-1:0]          ce = '0;
  logic [NUM_CH-1:0]          ue = '0;
  logic [DATA_W-1:0]          rdata;
  logic                       irq;

  ddr4_mc_regfile #(
    .NUM_CH(NUM_CH), .STATUS_W(STATUS_W), .CNT_W(CNT_W), .CALIB_TIMEOUT_CYC(TO_CYC),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BSEL_W(BSEL_W)
  ) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .config_en_i           (en),
    .config_wben_i         (wben),
    .config_addr_i         (addr),
    .config_wdata_i        (wdata),
    .config_rdata_o        (rdata),
    .ddr4_status_i         (status),
    .ddr4_calib_complete_i (calib),
    .ddr4_ecc_ce_i         (ce),
    .ddr4_ecc_ue_i         (ue),
    .irq_o                 (irq)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        rd_sampled = 1'b0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) rd_sampled <= en && (wben == '0);

  // Reads pop the scoreboard; every other cycle rdata must be zero.
  always @(negedge clk) begin
    if (rd_sampled) begin
      if (exp_q.size() == 0) chk("sb_empty", 64'(exp_q.size()), 64'd1);
      else chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    end else begin
      chk("rdata_idle", rdata, 64'h0);
    end
  end

  task automatic cfg_rd(input logic [31:0] a, input logic [63:0] e, input string tag);
    en = 1'b1; wben = '0; addr = a;
    exp_q.push_back(e); tag_q.push_back(tag);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    en = 1'b1; wben = be; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wben = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] cal);
    calib = cal; ce = '0; ue = '0; en = 1'b0; reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
  endtask

  // Leaves inputs to be driven now so they are sampled on post-reset edge k.
  task automatic goto_cycle(input int k);
    int g = 0;
    while (cyc != k - 1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("goto_timeout", 64'(cyc), 64'(k - 1));
  endtask

  task automatic pulse_ce(input int ch, input int n);
    repeat (n) begin
      ce[ch] = 1'b1;
      @(negedge clk);
      ce[ch] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    status = {16'hBEEF, 16'h1234};
    do_reset(2'b00);
    chk("rst_irq", irq, 64'h0);
    chk("rst_rdata", rdata, 64'h0);

    // Calibration never completes: flag appears on edge 16
    goto_cycle(16);
    cfg_rd(32'h08, 64'h0, "calib0_pre_to");
    cfg_rd(32'h08, TO_BIT, "calib0_to");
    cfg_rd(32'h00, 64'h1234, "status_ch0");
    cfg_rd(32'h20, 64'hBEEF, "status_ch1");
    cfg_wr(32'h00, '1, 8'hFF);
    cfg_rd(32'h00, 64'h1234, "status_ro");
    cfg_wr(32'h08, 64'h2, 8'h01);
    cfg_rd(32'h08, 64'h0, "calib0_w1c");
    cfg_rd(32'h28, TO_BIT, "calib1_to");

    do_reset(2'b10);
    idle(1);
    cfg_rd(32'h28, 64'h1, "calib1_done");
    cfg_rd(32'h08, 64'h0, "calib0_not_done");

    // Complete on edge 10, drop on edge 50, timeout on edge 66
    do_reset(2'b00);
    goto_cycle(10);
    calib = 2'b01;
    goto_cycle(20);
    cfg_rd(32'h08, 64'h1, "recal_done");
    goto_cycle(50);
    calib = 2'b00;
    goto_cycle(66);
    cfg_rd(32'h08, 64'h0, "recal_pre_to");
    cfg_rd(32'h08, TO_BIT, "recal_to");

    pulse_ce(0, 5);
    cfg_rd(32'h10, 64'h5, "ce_5");
    pulse_ce(0, 15);
    cfg_rd(32'h10, 64'hF, "ce_sat");
    en = 1'b1; wben = 8'hFF; addr = 32'h10; wdata = '0; ce[0] = 1'b1;
    @(negedge clk);
    en = 1'b0; wben = '0; ce[0] = 1'b0;
    cfg_rd(32'h10, 64'h1, "ce_clr_pulse");

    cfg_wr(32'h38, 64'h1, 8'h01);
    cfg_rd(32'h38, 64'h1, "ctrl1");
    ue[1] = 1'b1;
    @(negedge clk);
    ue[1] = 1'b0;
    chk("irq_latency", irq, 64'h0);
    idle(1);
    chk("irq_set", irq, 64'h1);
    cfg_rd(32'h100, 64'h2, "irq_pend");
    cfg_rd(32'h30, 64'h1_0000_0000, "ue_1");
    cfg_wr(32'h30, 64'h0, 8'hFF);
    chk("irq_hold", irq, 64'h1);
    idle(1);
    chk("irq_clr", irq, 64'h0);
    cfg_rd(32'h100, 64'h0, "pend_clr");

    ue[1] = 1'b1;
    @(negedge clk);
    ue[1] = 1'b0;
    idle(1);
    chk("irq_set2", irq, 64'h1);
    cfg_wr(32'h38, 64'h0, 8'h02);
    idle(1);
    chk("irq_gated", irq, 64'h1);
    cfg_rd(32'h38, 64'h1, "ctrl_gated");
    cfg_wr(32'h38, 64'h0, 8'h01);
    idle(1);
    chk("irq_mask", irq, 64'h0);

    cfg_rd(32'h48, 64'h0, "unmapped_ch2");
    cfg_wr(32'h58, 64'h1, 8'hFF);
    cfg_rd(32'h58, 64'h0, "unmapped_wr");
    cfg_rd(32'h18, 64'h0, "no_alias_ch0");
    cfg_rd(32'h04, 64'h0, "misaligned");
    cfg_rd(32'h108, 64'h0, "past_global");

    // Asynchronous reset with irq high and rdata non-zero
    pulse_ce(0, 3);
    cfg_wr(32'h38, 64'h1, 8'h01);
    idle(1);
    chk("irq_pre_rst", irq, 64'h1);
    cfg_rd(32'h10, 64'h4, "ce_pre_rst");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 64'h0);
    chk("async_rst_irq", irq, 64'h0);
    idle(2);
    reset_n = 1'b1;
    cfg_rd(32'h00, 64'h0, "status_rst");
    cfg_rd(32'h10, 64'h0, "ce_rst");
    cfg_rd(32'h30, 64'h0, "ue_rst");
    cfg_rd(32'h38, 64'h0, "ctrl_rst");
    cfg_rd(32'h100, 64'h0, "pend_rst");
    chk("irq_rst", irq, 64'h0);

    idle(2);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
